tmu_meshfetch: RTL
==================

# tmu_meshfetch

Wishbone read master that walks the vertex mesh the PFPU writes to memory and streams each vertex, with its mesh indices, to the texture-mapping pipeline. It sits directly downstream of the PFPU DMA: same mesh geometry (hmesh_last/vmesh_last), same 8-byte-per-vertex memory layout. It feeds the TMU rasterizer through a stb/ack pipeline handshake.

## Interface
Parameters:
- none

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a mesh walk when idle
- busy  out  1  high from cycle after accepted start until walk complete
- mesh_base  in  15  mesh base, address bits [31:17] (128 KB aligned)
- hmesh_last  in  7  last horizontal mesh index (columns = hmesh_last+1)
- vmesh_last  in  7  last vertical mesh index (rows = vmesh_last+1)
- wbm_adr_o  out  32  read address
- wbm_dat_i  in  32  read data
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  strobe; equal to wbm_cyc_o
- wbm_ack_i  in  1  read acknowledge
- pipe_stb_o  out  1  vertex valid to downstream
- pipe_ack_i  in  1  downstream accepts vertex
- mx, my  out  7 each  mesh indices of presented vertex
- vx, vy  out  32 each  vertex words (offset +0, +4)

## Operation
- Vertex address: {mesh_base, y[6:0], x[6:0], 3'b000}; vx at +0, vy at +4. Matches PFPU DMA write layout.
- Walk order: x inner (0..hmesh_last), y outer (0..vmesh_last); total (hmesh_last+1)*(vmesh_last+1) vertices.
- mesh_base, hmesh_last and vmesh_last are latched on accepted start; changes during a walk have no effect.
- FSM states: IDLE, FETCH0 (read +0), FETCH1 (read +4), PUSH (write vertex to output stage), DONE.
- IDLE -> FETCH0 on start. FETCH0 -> FETCH1 on wbm_ack_i (vx captured). FETCH1 -> PUSH on wbm_ack_i (vy captured).
- PUSH: if output stage has room, write vertex; if last vertex -> DONE, else advance x (wrap to 0, increment y) -> FETCH0. If no room, stay in PUSH.
- DONE -> IDLE once output stage is empty (last vertex accepted).
- start while busy: ignored.
- Handshake out: vertex transferred on cycle with pipe_stb_o & pipe_ack_i. pipe_stb_o, mx, my, vx and vy hold stable while pipe_stb_o=1 and pipe_ack_i=0.
- pipe_ack_i with pipe_stb_o=0: ignored.
- hmesh_last=vmesh_last=0: single vertex fetched and presented.

## Timing
- Reset values: busy=0, wbm_cyc_o=wbm_stb_o=0, wbm_adr_o=0, pipe_stb_o=0, mx=my=0, vx=vy=0. FSM to IDLE, counters to 0.
- Reset mid-walk: cyc/stb drop on the cycle after reset is sampled. Pending bus cycle and buffered vertices are abandoned.
- start sampled in cycle N: busy=1 and cyc/stb=1 with the address of vertex (0,0) in N+1.
- cyc/stb stay high through FETCH0 and FETCH1. Address changes to +4 in the cycle after the first ack, with no idle cycle. cyc/stb drop in the cycle after the second ack.
- Bus latency per vertex with zero-wait slave (ack the cycle after stb): 2 cycles bus + 1 cycle PUSH.
- Output stage written in PUSH: pipe_stb_o asserts the next cycle.
- busy falls in the cycle after the last vertex's pipe_ack_i.
- Wishbone cycle is never terminated early; the ack is always awaited.

## Configuration
- TMU_MESHFETCH_PREFETCH_EN defined:
  - Output stage is a 4-entry FIFO.
  - Fetching continues while downstream stalls, until the FIFO is full.
  - Simultaneous push and pop when full is allowed (pop frees the slot the same cycle).
- Undefined:
  - Output stage is a single register.
  - PUSH waits until the register is empty or is being acked that cycle; no prefetch beyond one vertex.

## Test plan
- Reset then start, mesh_base=15'h0001, hmesh_last=vmesh_last=0, zero-wait slave -> reads at 0x00020000 and 0x00020004; one vertex mx=my=0 with vx/vy equal to the slave data; busy low after ack.
- hmesh_last=2, vmesh_last=1, pipe_ack_i held 1 -> 6 vertices in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); second-row addresses have bit 10 set (y=1).
- pipe_ack_i held 0 for 20 cycles mid-walk -> output stable throughout. With macro: exactly 4 vertices buffered, then cyc low. Without: 1 buffered.
- Slave inserting 3 wait states per ack -> adr/stb stable until ack; data matches; no dropped or duplicated vertices.
- Start pulse while busy -> ignored; vertex count unchanged; latched geometry unaffected by input changes.
- sys_rst asserted while cyc=1 -> all outputs at reset values next cycle; a new start then walks correctly from (0,0).

Source files
------------

// File: rtl/tmu_meshfetch.sv
// tmu_meshfetch
//   Wishbone read master that walks the PFPU vertex mesh and streams each
//   vertex, tagged with its mesh indices, to the TMU rasterizer.
//   Vertex (x,y) lives at {mesh_base, y, x, 3'b000}: vx at +0, vy at +4.
//   Walk order is x inner, y outer.
//
// Ports
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   start, busy             walk request pulse / walk in progress
//   mesh_base               address bits [31:17] of the mesh
//   hmesh_last, vmesh_last  last column / row index
//   wbm_*                   Wishbone read master
//   pipe_stb_o, pipe_ack_i  vertex handshake to downstream
//   mx, my, vx, vy          presented vertex indices and data words
//
// Configuration
//   TMU_MESHFETCH_PREFETCH_EN  when defined, the output stage is a 4-entry
//                              FIFO so fetching runs ahead of a stalled
//                              consumer; otherwise a single register.

module tmu_meshfetch (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  output logic        busy,
  input  logic [14:0] mesh_base,
  input  logic [6:0]  hmesh_last,
  input  logic [6:0]  vmesh_last,
  output logic [31:0] wbm_adr_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  output logic        pipe_stb_o,
  input  logic        pipe_ack_i,
  output logic [6:0]  mx,
  output logic [6:0]  my,
  output logic [31:0] vx,
  output logic [31:0] vy
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH0,
    FETCH1,
    PUSH,
    DONE
  } state_t;

  state_t      state;
  logic [14:0] base_q;
  logic [6:0]  hlast_q;
  logic [6:0]  vlast_q;
  logic [6:0]  x_q;
  logic [6:0]  y_q;
  logic [31:0] vx_q;
  logic [31:0] vy_q;

  logic        push;
  logic        pop;
  logic        room;
  logic        empty_next;
  logic        last_vtx;
  logic [77:0] new_vtx;

  assign last_vtx = (x_q == hlast_q) && (y_q == vlast_q);
  assign push     = (state == PUSH) && room;
  assign new_vtx  = {x_q, y_q, vx_q, vy_q};

  assign busy      = (state != IDLE);
  assign wbm_cyc_o = (state == FETCH0) || (state == FETCH1);
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_adr_o = wbm_cyc_o ? {base_q, y_q, x_q, (state == FETCH1), 2'b00} : '0;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      base_q  <= '0;
      hlast_q <= '0;
      vlast_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q  <= mesh_base;
            hlast_q <= hmesh_last;
            vlast_q <= vmesh_last;
            x_q     <= '0;
            y_q     <= '0;
            state   <= FETCH0;
          end
        end
        FETCH0: begin
          if (wbm_ack_i) begin
            vx_q  <= wbm_dat_i;
            state <= FETCH1;
          end
        end
        FETCH1: begin
          if (wbm_ack_i) begin
            vy_q  <= wbm_dat_i;
            state <= PUSH;
          end
        end
        PUSH: begin
          if (room) begin
            if (last_vtx) begin
              state <= DONE;
            end else begin
              if (x_q == hlast_q) begin
                x_q <= '0;
                y_q <= y_q + 7'd1;
              end else begin
                x_q <= x_q + 7'd1;
              end
              state <= FETCH0;
            end
          end
        end
        DONE: begin
          // Nothing is pushed in DONE, so the stage drains only by pops.
          if (empty_next) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TMU_MESHFETCH_PREFETCH_EN
  logic [77:0] fifo_mem [4];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic [2:0]  count;

  // A pop while full frees the head slot, which is also the write slot;
  // the head is read combinationally before the edge overwrites it.
  assign pop        = (count != 3'd0) && pipe_ack_i;
  assign room       = (count != 3'd4) || pop;
  assign empty_next = (count == 3'd0) || ((count == 3'd1) && pop);

  assign pipe_stb_o        = (count != 3'd0);
  assign {mx, my, vx, vy}  = fifo_mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= new_vtx;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
`else
  logic        out_valid;
  logic [77:0] out_q;

  assign pop        = out_valid && pipe_ack_i;
  assign room       = !out_valid || pipe_ack_i;
  assign empty_next = !out_valid || pop;

  assign pipe_stb_o       = out_valid;
  assign {mx, my, vx, vy} = out_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (push) begin
      out_valid <= 1'b1;
      out_q     <= new_vtx;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule
